// File: rtl/truth_table_sweeper.sv
// Exhaustive 32-vector stimulus sequencer that captures Z into a truth table and checks it against a golden signature.
// Optional feature: define SWEEP_PAUSE_EN to add a 'pause' input that stalls the sweep while in HOLD.
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [4:0] START_CODE    = 5'b10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        z_in,
`ifdef SWEEP_PAUSE_EN
  input  logic        pause,
`endif
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] truth_table,
  output logic [5:0]  mismatch_count,
  output logic [4:0]  first_fail,
  output logic        fail_seen
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  settle_cnt;
  logic [4:0]  idx;
  logic [31:0] exp_latched;
  logic        stall;
  logic        sample;
  logic        last_sample;
  logic        mismatch;
  logic [5:0]  mismatch_next;

`ifdef SWEEP_PAUSE_EN
  assign stall = pause && (state == HOLD);
`else
  assign stall = 1'b0;
`endif

  assign sample        = (state == HOLD) && !stall && (settle_cnt == 4'd0);
  assign last_sample   = sample && (idx == 5'd31);
  assign mismatch      = (z_in != exp_latched[vec]);
  assign mismatch_next = mismatch ? mismatch_count + 6'd1 : mismatch_count;

  assign busy = (state == HOLD);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = HOLD;
      HOLD:    if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pass is resolved on the final sample so it is already valid in the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= 5'd0;
      pass           <= 1'b0;
      truth_table    <= 32'd0;
      mismatch_count <= 6'd0;
      first_fail     <= 5'd0;
      fail_seen      <= 1'b0;
      settle_cnt     <= 4'd0;
      idx            <= 5'd0;
      exp_latched    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_latched    <= expected;
            truth_table    <= 32'd0;
            mismatch_count <= 6'd0;
            first_fail     <= 5'd0;
            fail_seen      <= 1'b0;
            pass           <= 1'b0;
            vec            <= START_CODE;
            settle_cnt     <= SETTLE_INIT;
            idx            <= 5'd0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if (settle_cnt != 4'd0) begin
              settle_cnt <= settle_cnt - 4'd1;
            end else begin
              truth_table[vec] <= z_in;
              mismatch_count   <= mismatch_next;
              if (mismatch && !fail_seen) begin
                first_fail <= vec;
                fail_seen  <= 1'b1;
              end
              if (last_sample) begin
                pass <= (mismatch_next == 6'd0);
              end else begin
                vec        <= vec + 5'd1;
                idx        <= idx + 5'd1;
                settle_cnt <= SETTLE_INIT;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper driving a Z = a & b circuit; run with SWEEP_PAUSE_EN to cover pausing.
module tb_truth_table_sweeper;

  localparam int         SETTLE   = 2;
  localparam logic [4:0] START    = 5'b10000;
  localparam int         BASE_LAT = 1 + 32 * (SETTLE + 1);

  typedef struct packed {
    logic [31:0] tt;
    logic [5:0]  mc;
    logic [4:0]  ff;
    logic        fs;
    logic        ps;
  } result_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] expected = 32'd0;
  logic        z_in;
  logic        pause = 1'b0;
  logic [4:0]  vec;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] truth_table;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_fail;
  logic        fail_seen;

  int checks = 0;
  int errors = 0;
  result_t     exp_q[$];
  logic [4:0]  vec_q[$];

  truth_table_sweeper #(.SETTLE_CYCLES(SETTLE), .START_CODE(START)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .expected(expected),
    .z_in(z_in),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .vec(vec),
    .busy(busy),
    .done(done),
    .pass(pass),
    .truth_table(truth_table),
    .mismatch_count(mismatch_count),
    .first_fail(first_fail),
    .fail_seen(fail_seen)
  );

  // circuit under test: Z = a & b
  assign z_in = vec[4] & vec[3];

  always #5 clk = ~clk;

  function automatic result_t model(input logic [31:0] exp_tbl);
    result_t r;
    logic [4:0] v;
    logic z;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      v = 5'(START + 5'(k));
      z = v[4] & v[3];
      r.tt[v] = z;
      if (z != exp_tbl[v]) begin
        if (r.mc == 6'd0) r.ff = v;
        r.mc = r.mc + 6'd1;
        r.fs = 1'b1;
      end
    end
    r.ps = (r.mc == 6'd0);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({vec, busy, done, pass} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl vec=%0d busy=%b done=%b pass=%b, want all 0", vec, busy, done, pass);
    end
    checks++;
    if ({truth_table, mismatch_count, first_fail, fail_seen} !== 44'd0) begin
      errors++;
      $display("[TB] FAIL reset_results tt=%h mc=%0d ff=%0d fs=%b, want all 0",
               truth_table, mismatch_count, first_fail, fail_seen);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_sweep(input logic [31:0] exp_tbl, input int pause_len, input bit hold_start,
                           input string tag);
    result_t want;
    result_t got;
    int lat;
    logic [4:0] v_before;
    exp_q.push_back(model(exp_tbl));
    @(negedge clk);
    expected = exp_tbl;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_busy got %b want 1", tag, busy);
    end
    while (done !== 1'b1 && lat < 600) begin
      if (hold_start && lat == 40) expected = 32'h0;
      if (pause_len > 0 && lat == 30) begin
        pause = 1'b1;
        v_before = vec;
        repeat (pause_len) begin
          @(negedge clk);
          lat++;
        end
        checks++;
        if (vec !== v_before || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s_pause_freeze vec=%0d busy=%b want vec=%0d busy=1", tag, vec, busy, v_before);
        end
        pause = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (hold_start) start = 1'b0;
    checks++;
    if (lat != BASE_LAT + pause_len) begin
      errors++;
      $display("[TB] FAIL %s_latency got %0d want %0d", tag, lat, BASE_LAT + pause_len);
    end
    got = '{truth_table, mismatch_count, first_fail, fail_seen, pass};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_scoreboard got empty queue want one entry", tag);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s_result got tt=%h mc=%0d ff=%0d fs=%b pass=%b want tt=%h mc=%0d ff=%0d fs=%b pass=%b",
                 tag, got.tt, got.mc, got.ff, got.fs, got.ps, want.tt, want.mc, want.ff, want.fs, want.ps);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== want.ps || truth_table !== want.tt) begin
      errors++;
      $display("[TB] FAIL %s_hold done=%b busy=%b pass=%b tt=%h want done=0 busy=0 pass=%b tt=%h",
               tag, done, busy, pass, truth_table, want.ps, want.tt);
    end
  endtask

  task automatic test_basic_pass();
    run_sweep(32'hFF000000, 0, 1'b0, "basic");
  endtask

  task automatic test_single_mismatch();
    run_sweep(32'hFF000001, 0, 1'b0, "mismatch");
  endtask

  task automatic test_start_held();
    run_sweep(32'hFF000000, 0, 1'b1, "held");
  endtask

  task automatic test_vec_sequence();
    int bad = 0;
    for (int c = 0; c < 32 * (SETTLE + 1); c++) vec_q.push_back(5'(16 + c / (SETTLE + 1)));
    @(negedge clk);
    expected = 32'hFF000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (vec_q.size() > 0) begin
      checks++;
      if (vec !== vec_q[0]) begin
        errors++;
        $display("[TB] FAIL vec_seq got %0d want %0d", vec, vec_q[0]);
      end
      void'(vec_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL vec_seq_done got %b want 1", done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (vec !== 5'd15) begin
      errors++;
      $display("[TB] FAIL vec_after_done got %0d want 15", vec);
    end
  endtask

  task automatic test_rst_mid_sweep();
    int n = 0;
    int done_cnt = 0;
    @(negedge clk);
    expected = 32'hFF000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (vec !== 5'd4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vec !== 5'd4) begin
      errors++;
      $display("[TB] FAIL rst_reach_vec4 got %0d want 4", vec);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec !== 5'd0 || truth_table !== 32'd0 || done !== 1'b0 || mismatch_count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rst_abort busy=%b vec=%0d tt=%h done=%b mc=%0d want 0", busy, vec, truth_table, done,
               mismatch_count);
    end
    rst = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("[TB] FAIL rst_no_done got %0d pulses want 0", done_cnt);
    end
    run_sweep(32'hFF000000, 0, 1'b0, "after_rst");
  endtask

`ifdef SWEEP_PAUSE_EN
  task automatic test_pause();
    run_sweep(32'hFF000000, 10, 1'b0, "pause");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pass();
    test_single_mismatch();
    test_vec_sequence();
    test_start_held();
    test_rst_mid_sweep();
`ifdef SWEEP_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
